// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority sampling,
// a held-byte valid/ack handshake and a sticky overrun flag.
//
// Handshake: rxValid rises with rxDone and stays high until rxAck is seen
// high on a rising clock edge. If rxAck and a new good frame land in the
// same cycle, the new byte wins: rxValid stays high and rxOverrun is not set.
module uart_rx_oversample #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rxIn,
  input  logic       rxAck,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  output logic       rxValid,
  output logic       rxOverrun,
  output logic [2:0] state_dbg
);

  localparam int DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state;
  logic          sync1, sync2, rxs_d;
  logic          rxS, fall_edge, start_go, tick;
  logic [CW-1:0] div_cnt;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [2:0]    votes;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign rxS       = sync2;
  assign fall_edge = rxs_d & ~rxS;
  assign start_go  = (state == IDLE) && rxEn && fall_edge;
  assign tick      = (div_cnt == DIV_LAST);
  assign state_dbg = state;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxIn;
      sync2 <= sync1;
      rxs_d <= sync2;
    end
  end

  // Oversample tick divider; restarts on a detected start edge to phase-align sampling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (start_go || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Receive FSM with registered status outputs and the valid/ack/overrun handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick_cnt  <= 4'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      votes     <= 3'b000;
      rxBusy    <= 1'b0;
      rxDone    <= 1'b0;
      rxErr     <= 1'b0;
      rxOut     <= 8'h00;
      rxValid   <= 1'b0;
      rxOverrun <= 1'b0;
    end else begin
      rxDone <= 1'b0;
      rxErr  <= 1'b0;
      if (rxAck) begin
        rxValid   <= 1'b0;
        rxOverrun <= 1'b0;
      end
      if (!rxEn) begin
        // Disable discards any partial frame silently.
        state  <= IDLE;
        rxBusy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fall_edge) begin
              state    <= START;
              rxBusy   <= 1'b1;
              tick_cnt <= 4'd0;
            end
          end
          START: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd7 && rxS) begin
                rxErr  <= 1'b1;
                rxBusy <= 1'b0;
                state  <= IDLE;
              end else if (tick_cnt == 4'd15) begin
                bit_idx <= 3'd0;
                state   <= DATA;
              end
            end
          end
          DATA: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd7) votes[0] <= rxS;
              if (tick_cnt == 4'd8) votes[1] <= rxS;
              if (tick_cnt == 4'd9) votes[2] <= rxS;
              if (tick_cnt == 4'd15) begin
                shreg   <= {maj3(votes[0], votes[1], votes[2]), shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) state <= STOP;
              end
            end
          end
          STOP: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd7) votes[0] <= rxS;
              if (tick_cnt == 4'd8) votes[1] <= rxS;
              if (tick_cnt == 4'd9) begin
                rxBusy <= 1'b0;
                if (maj3(votes[0], votes[1], rxS)) begin
                  rxOut   <= shreg;
                  rxDone  <= 1'b1;
                  rxValid <= 1'b1;
                  if (rxValid && !rxAck) rxOverrun <= 1'b1;
                  state   <= IDLE;
                end else begin
                  // A low stop bit may be a break; wait for the line to recover.
                  rxErr <= 1'b1;
                  state <= WAIT_HIGH;
                end
              end
            end
          end
          WAIT_HIGH: begin
            if (tick && rxS) state <= IDLE;
          end
          default: begin
            state  <= IDLE;
            rxBusy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
